// File: rtl/note_detector.sv
// note_detector: identifies which scale note C4..C5 a square wave carries.
// A note is declared only after CONFIRM consecutive agreeing periods.
module note_detector #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int TOL_SHIFT = 6,
  parameter int CONFIRM   = 3,
  parameter int CNT_W     = 20
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             FREQ_IN,
  output logic [3:0]       note,
  output logic             note_valid,
  output logic             note_change,
  output logic [CNT_W-1:0] period
);

  localparam int DW = CNT_W + 1;
  localparam int MW = $clog2(CONFIRM + 1);
  localparam logic [MW-1:0] CONF = MW'(CONFIRM);

  function automatic logic [CNT_W-1:0] nominal(input int k);
    longint unsigned base;
    longint unsigned hz;
    hz = longint'(CLK_HZ);
    case (k)
      1:       base = 64'd382219;
      2:       base = 64'd340530;
      3:       base = 64'd303370;
      4:       base = 64'd286344;
      5:       base = 64'd255102;
      6:       base = 64'd227272;
      7:       base = 64'd202478;
      default: base = 64'd191113;
    endcase
    return CNT_W'((base * hz) / 64'd100_000_000);
  endfunction

  localparam logic [CNT_W-1:0] TIMEOUT = nominal(1) << 1;

  typedef enum logic {IDLE, MEASURE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             s1, s2, s3;
  logic             strobe;
  logic             pv;
  logic             cls_v;
  logic [3:0]       cls, cls_d;
  logic [3:0]       cand, nc;
  logic [MW-1:0]    match, nm;
  logic [8:1]       hit;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= FREQ_IN;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign strobe = s2 & ~s3;

  for (genvar k = 1; k <= 8; k++) begin : g_win
    localparam logic [CNT_W-1:0] P = nominal(k);
    localparam logic [DW-1:0]    W = DW'(P >> TOL_SHIFT);
    logic [DW-1:0] diff;
    assign diff = (period >= P) ?
                  ({1'b0, period} - {1'b0, P}) :
                  ({1'b0, P} - {1'b0, period});
    assign hit[k] = (diff <= W);
  end

  // windows are disjoint, so at most one hit is set
  always_comb begin
    cls_d = 4'd0;
    unique case (1'b1)
      hit[1]:  cls_d = 4'd1;
      hit[2]:  cls_d = 4'd2;
      hit[3]:  cls_d = 4'd3;
      hit[4]:  cls_d = 4'd4;
      hit[5]:  cls_d = 4'd5;
      hit[6]:  cls_d = 4'd6;
      hit[7]:  cls_d = 4'd7;
      hit[8]:  cls_d = 4'd8;
      default: cls_d = 4'd0;
    endcase
  end

  always_comb begin
    nm = MW'(1);
    nc = cls;
    if (cls == cand) begin
      nc = cand;
      nm = (match == CONF) ? match : match + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= IDLE;
      cnt         <= '0;
      period      <= '0;
      pv          <= 1'b0;
      cls         <= 4'd0;
      cls_v       <= 1'b0;
      cand        <= 4'd0;
      match       <= '0;
      note        <= 4'd0;
      note_valid  <= 1'b0;
      note_change <= 1'b0;
    end else begin
      note_change <= 1'b0;
      pv          <= 1'b0;
      cls_v       <= pv;
      if (pv) cls <= cls_d;
      if (cls_v) begin
        cand  <= nc;
        match <= nm;
        if (nm == CONF && nc != note) begin
          note        <= nc;
          note_valid  <= (nc != 4'd0);
          note_change <= 1'b1;
        end
      end
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (strobe) begin
            state <= MEASURE;
            cnt   <= CNT_W'(1);
          end
        end
        MEASURE: begin
          // timeout takes priority over a coincident edge
          if (cnt == TIMEOUT) begin
            state       <= IDLE;
            cnt         <= '0;
            note        <= 4'd0;
            note_valid  <= 1'b0;
            match       <= '0;
            cand        <= 4'd0;
            note_change <= (note != 4'd0);
          end else if (strobe) begin
            period <= cnt;
            cnt    <= CNT_W'(1);
            pv     <= 1'b1;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
